// File: rtl/alu_lane_sequencer_if.sv
// Bundle between the ALU issue logic, the sequencer and the shared 8-bit logic lane.
// Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1;
// once valid is raised it is held with stable payload until that edge.
interface alu_lane_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int LANE  = 8
);
    // request side
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    // shared lane side
    logic             lane_en;
    logic [1:0]       lane_op;
    logic [LANE-1:0]  lane_a;
    logic [LANE-1:0]  lane_b;
    logic [LANE-1:0]  lane_y;
    // result side
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             busy;
    // FSM state for observation (0 IDLE, 1 RUN, 2 DONE)
    logic [1:0]       dbg_state;

    // issue logic, lane unit and result consumer
    modport master (
        output in_valid, op, a, b, lane_y, out_ready,
        input  in_ready, lane_en, lane_op, lane_a, lane_b, out_valid, y, zero, busy, dbg_state
    );

    // the sequencer
    modport slave (
        input  in_valid, op, a, b, lane_y, out_ready,
        output in_ready, lane_en, lane_op, lane_a, lane_b, out_valid, y, zero, busy, dbg_state
    );
endinterface

// File: rtl/alu_lane_sequencer.sv
// Runs a WIDTH-bit bitwise op through the shared LANE-bit logic unit, one slice per
// cycle LSB first, assembles the result and holds it until the consumer takes it.
module alu_lane_sequencer #(
    parameter int WIDTH = 32,
    parameter int LANE  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_lane_sequencer_if.slave  bus
);
    localparam int BEATS = WIDTH / LANE;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [BW-1:0]    beat;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [1:0]       op_reg;
    logic [WIDTH-1:0] y_reg;
    logic             in_ready_int;
    logic             accept;

    // ready only in IDLE, and never while reset is asserted
    assign in_ready_int = (state == IDLE) && !rst;
    assign accept       = bus.in_valid && in_ready_int;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = RUN;
            RUN:  if (beat == LAST_BEAT) state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // operand capture, beat counter and per-beat result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat   <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            op_reg <= '0;
            y_reg  <= '0;
        end else begin
            if (state == IDLE && accept) begin
                a_reg  <= bus.a;
                b_reg  <= bus.b;
                op_reg <= bus.op;
                beat   <= '0;
            end else if (state == RUN) begin
                y_reg[int'(beat)*LANE +: LANE] <= bus.lane_y;
                beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
            end
        end
    end

    // outputs decoded from state and registers only; lane_y never reaches y directly
    always_comb begin
        bus.in_ready  = in_ready_int;
        bus.lane_en   = 1'b0;
        bus.lane_op   = 2'b00;
        bus.lane_a    = '0;
        bus.lane_b    = '0;
        bus.out_valid = 1'b0;
        bus.y         = y_reg;
        bus.zero      = 1'b0;
        bus.busy      = (state != IDLE);
        bus.dbg_state = state;
        if (state == RUN) begin
            bus.lane_en = 1'b1;
            bus.lane_op = op_reg;
            bus.lane_a  = a_reg[int'(beat)*LANE +: LANE];
            bus.lane_b  = b_reg[int'(beat)*LANE +: LANE];
        end
        if (state == DONE) begin
            bus.out_valid = 1'b1;
            bus.zero      = (y_reg == '0);
        end
    end
endmodule

// File: tb/tb_alu_lane_sequencer.sv
// Directed bench for alu_lane_sequencer; the bench also plays the 8-bit logic lane.
module tb_alu_lane_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    alu_lane_sequencer_if #(.WIDTH(32), .LANE(8)) bus ();

    alu_lane_sequencer #(.WIDTH(32), .LANE(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock
    always #5 clk = ~clk;

    // external lane unit: combinational bitwise op
    always_comb begin
        case (bus.lane_op)
            2'b00:   bus.lane_y = bus.lane_a & bus.lane_b;
            2'b01:   bus.lane_y = bus.lane_a | bus.lane_b;
            2'b10:   bus.lane_y = bus.lane_a ^ bus.lane_b;
            default: bus.lane_y = ~(bus.lane_a & bus.lane_b);
        endcase
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // wait (bounded) for in_ready, present the op for one accepting edge
    task automatic issue(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
        int n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("issue_ready", {63'd0, bus.in_ready}, 64'd1);
        bus.in_valid = 1'b1;
        bus.op = o;
        bus.a = av;
        bus.b = bv;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // from the first RUN cycle, wait for the result and check latency/value
    task automatic wait_out(input string tag, input logic [31:0] ey, input logic ez);
        int n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'd4);
        check({tag, "_y"}, {32'd0, bus.y}, {32'd0, ey});
        check({tag, "_zero"}, {63'd0, bus.zero}, {63'd0, ez});
    endtask

    task automatic deliver();
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("deliver_ov", {63'd0, bus.out_valid}, 64'd0);
        check("deliver_rdy", {63'd0, bus.in_ready}, 64'd1);
        bus.out_ready = 1'b0;
    endtask

    logic [7:0]  exp_la [4];
    logic [7:0]  exp_lb [4];
    logic [31:0] all_exp [4];
    logic [31:0] exp_q [$];
    logic [31:0] b2b_a [3];
    logic [31:0] b2b_b [3];
    int          acc_cyc [$];
    int          pulses;
    int          cyc;
    int          n_acc;
    int          n_del;

    initial begin
        bus.in_valid  = 1'b0;
        bus.op        = 2'b00;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;

        // ---- reset state
        @(negedge clk);
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_lane_en", {63'd0, bus.lane_en}, 64'd0);
        check("rst_y", {32'd0, bus.y}, 64'd0);
        check("rst_zero", {63'd0, bus.zero}, 64'd0);
        rst = 1'b0;
        #1;
        check("rel_in_ready", {63'd0, bus.in_ready}, 64'd1);
        @(negedge clk);

        // ---- reset in the middle of an op
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clk);
        @(negedge clk);
        check("mid_lane_en", {63'd0, bus.lane_en}, 64'd1);
        check("mid_y_partial", {32'd0, bus.y}, 64'h0000_FFFF);
        rst = 1'b1;
        #1;
        check("mid_rst_lane_en", {63'd0, bus.lane_en}, 64'd0);
        check("mid_rst_lane_a", {56'd0, bus.lane_a}, 64'd0);
        check("mid_rst_lane_op", {62'd0, bus.lane_op}, 64'd0);
        check("mid_rst_busy", {63'd0, bus.busy}, 64'd0);
        check("mid_rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        check("mid_rst_y", {32'd0, bus.y}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rel_in_ready", {63'd0, bus.in_ready}, 64'd1);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid || bus.busy) pulses++;
        end
        check("mid_no_pulse", 64'(pulses), 64'd0);

        // ---- basic AND with per-beat lane checks, then backpressure
        exp_la = '{8'hAA, 8'hF0, 8'h00, 8'hFF};
        exp_lb = '{8'hAA, 8'hFF, 8'h0F, 8'h0F};
        issue(2'b00, 32'hFF00_F0AA, 32'h0F0F_FFAA);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("and_b%0d_en", i), {63'd0, bus.lane_en}, 64'd1);
            check($sformatf("and_b%0d_op", i), {62'd0, bus.lane_op}, 64'd0);
            check($sformatf("and_b%0d_a", i), {56'd0, bus.lane_a}, {56'd0, exp_la[i]});
            check($sformatf("and_b%0d_b", i), {56'd0, bus.lane_b}, {56'd0, exp_lb[i]});
            check($sformatf("and_b%0d_rdy", i), {63'd0, bus.in_ready}, 64'd0);
            // operand ports change during RUN; must not matter
            bus.a = $urandom;
            bus.b = $urandom;
            @(negedge clk);
        end
        check("and_ov", {63'd0, bus.out_valid}, 64'd1);
        check("and_y", {32'd0, bus.y}, 64'h0F00_F0AA);
        check("and_zero", {63'd0, bus.zero}, 64'd0);
        check("and_lane_en", {63'd0, bus.lane_en}, 64'd0);
        check("and_lane_a", {56'd0, bus.lane_a}, 64'd0);
        bus.in_valid = 1'b1;
        bus.op = 2'b00;
        bus.a = 32'hAAAA_AAAA;
        bus.b = 32'h5555_5555;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("bp%0d_ov", i), {63'd0, bus.out_valid}, 64'd1);
            check($sformatf("bp%0d_y", i), {32'd0, bus.y}, 64'h0F00_F0AA);
            check($sformatf("bp%0d_rdy", i), {63'd0, bus.in_ready}, 64'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_idle_ov", {63'd0, bus.out_valid}, 64'd0);
        check("bp_idle_rdy", {63'd0, bus.in_ready}, 64'd1);
        check("bp_idle_busy", {63'd0, bus.busy}, 64'd0);
        check("bp_idle_y_hold", {32'd0, bus.y}, 64'h0F00_F0AA);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("zf_accepted", {63'd0, bus.busy}, 64'd1);
        wait_out("zf", 32'h0000_0000, 1'b1);
        deliver();

        // ---- every op on one operand pair
        all_exp = '{32'h1234_0000, 32'hFFFF_5678, 32'hEDCB_5678, 32'hEDCB_FFFF};
        for (int k = 0; k < 4; k++) begin
            issue(2'(k), 32'h1234_5678, 32'hFFFF_0000);
            wait_out($sformatf("op%0d", k), all_exp[k], 1'b0);
            deliver();
        end

        // ---- back-to-back, out_ready tied high, in_valid held
        b2b_a = '{32'hDEAD_BEEF, 32'h0123_4567, 32'hFFFF_FFFF};
        b2b_b = '{32'hFFFF_0000, 32'h89AB_CDEF, 32'hFFFF_FFFF};
        bus.out_ready = 1'b1;
        bus.op = 2'b10;
        n_acc = 0;
        n_del = 0;
        for (cyc = 0; cyc < 40; cyc++) begin
            if (bus.out_valid) begin
                n_del++;
                if (exp_q.size() > 0) begin
                    check($sformatf("b2b_y%0d", n_del), {32'd0, bus.y}, {32'd0, exp_q.pop_front()});
                end else begin
                    check("b2b_unexpected_out", 64'd1, 64'd0);
                end
            end
            if (bus.in_ready && n_acc < 3) begin
                bus.in_valid = 1'b1;
                bus.a = b2b_a[n_acc];
                bus.b = b2b_b[n_acc];
                exp_q.push_back(b2b_a[n_acc] ^ b2b_b[n_acc]);
                acc_cyc.push_back(cyc);
                n_acc++;
            end else begin
                bus.in_valid = (n_acc < 3);
                bus.a = $urandom;
                bus.b = $urandom;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        check("b2b_accepts", 64'(n_acc), 64'd3);
        check("b2b_delivers", 64'(n_del), 64'd3);
        check("b2b_gap01", 64'(acc_cyc[1] - acc_cyc[0]), 64'd6);
        check("b2b_gap12", 64'(acc_cyc[2] - acc_cyc[1]), 64'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
